// File: rtl/bus_mst_pkg.sv
// bus_mst_pkg: FSM state encoding and bus command constants for bus_master_engine
package bus_mst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_REQ,
        ST_GAP,
        ST_DONE
    } mst_state_t;

    localparam logic CMD_WR = 1'b0;
    localparam logic CMD_RD = 1'b1;

endpackage

// File: rtl/mst_beat_timer.sv
// mst_beat_timer: loadable down-counter shared by the inter-beat gap and the ack timeout
module mst_beat_timer #(
    parameter int W = 6
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // load has priority; counting stops at zero
    always_ff @(posedge iClk) begin
        if (!iRst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = cnt == '0;

endmodule

// File: rtl/bus_master_engine.sv
// bus_master_engine: descriptor-driven bus master; define MST_TIMEOUT_EN to enable the ack timeout
module bus_master_engine
    import bus_mst_pkg::*;
#(
    parameter int AW     = 12,
    parameter int DW     = 32,
    parameter int SW     = DW / 8,
    parameter int LEN_W  = 8,
    parameter int GAP_W  = 4,
    parameter int TO_CYC = 64
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iDescValid,
    output logic             oDescReady,
    input  logic             iDescCmd,
    input  logic [AW-1:0]    iDescAddr,
    input  logic [SW-1:0]    iDescSel,
    input  logic [LEN_W-1:0] iDescLen,
    input  logic [GAP_W-1:0] iDescGap,
    input  logic             iWrValid,
    output logic             oWrReady,
    input  logic [DW-1:0]    iWrData,
    output logic             oRdValid,
    output logic [DW-1:0]    oRdData,
    output logic             oMstReq,
    output logic             oMstCmd,
    output logic [AW-1:0]    oMstAddr,
    output logic [SW-1:0]    oMstSel,
    output logic [DW-1:0]    oMstWData,
    input  logic             iMstAck,
    input  logic [DW-1:0]    iMstRData,
    output logic             oBusy,
    output logic             oDone,
    output logic             oErr
);

    localparam int TO_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
    localparam int TW   = (GAP_W > TO_W) ? GAP_W : TO_W;

    mst_state_t       state;
    logic [LEN_W-1:0] rem;
    logic [GAP_W-1:0] gap_q;
    logic             accept, ack, last, tmo, t_load, t_en, t_zero;
    logic [TW-1:0]    t_val;

    // handshake decode and timer control; the timer holds gap-1 in GAP and TO_CYC-1 on REQ entry
    always_comb begin
        accept = (state == ST_IDLE) && iDescValid && oDescReady;
        ack    = (state == ST_REQ) && oMstReq && iMstAck;
        last   = rem == LEN_W'(1);
`ifdef MST_TIMEOUT_EN
        tmo    = (state == ST_REQ) && !ack && t_zero;
        t_load = ack || (state inside {ST_IDLE, ST_FETCH, ST_DONE}) || (state == ST_GAP && t_zero);
        t_val  = (ack && gap_q != '0) ? TW'(gap_q - GAP_W'(1)) : TW'(TO_CYC - 1);
        t_en   = (state == ST_GAP) || (state == ST_REQ);
`else
        tmo    = 1'b0;
        t_load = ack;
        t_val  = TW'(gap_q - GAP_W'(1));
        t_en   = state == ST_GAP;
`endif
    end

    mst_beat_timer #(.W(TW)) u_timer (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .load     (t_load),
        .en       (t_en),
        .load_val (t_val),
        .zero     (t_zero)
    );

    // descriptor sequencer with registered bus and handshake outputs
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state      <= ST_IDLE;
            rem        <= '0;
            gap_q      <= '0;
            oDescReady <= 1'b0;
            oWrReady   <= 1'b0;
            oRdValid   <= 1'b0;
            oRdData    <= '0;
            oMstReq    <= 1'b0;
            oMstCmd    <= 1'b0;
            oMstAddr   <= '0;
            oMstSel    <= '0;
            oMstWData  <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oErr       <= 1'b0;
        end else begin
            oRdValid <= 1'b0;
            oDone    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    oDescReady <= !accept;
                    if (accept) begin
                        oBusy <= 1'b1;
                        oErr  <= 1'b0;
                        rem   <= iDescLen;
                        gap_q <= iDescGap;
                        if (iDescLen == '0) begin
                            oDone <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            oMstCmd  <= iDescCmd;
                            oMstAddr <= iDescAddr;
                            oMstSel  <= iDescSel;
                            if (iDescCmd == CMD_RD) begin
                                oMstReq <= 1'b1;
                                state   <= ST_REQ;
                            end else begin
                                oWrReady <= 1'b1;
                                state    <= ST_FETCH;
                            end
                        end
                    end
                end
                ST_FETCH: begin
                    if (iWrValid) begin
                        oWrReady  <= 1'b0;
                        oMstWData <= iWrData;
                        oMstReq   <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tmo) begin
                        oMstReq <= 1'b0;
                        oErr    <= 1'b1;
                        oDone   <= 1'b1;
                        state   <= ST_DONE;
                    end else if (ack) begin
                        rem <= rem - LEN_W'(1);
                        if (oMstCmd == CMD_RD) begin
                            oRdValid <= 1'b1;
                            oRdData  <= iMstRData;
                        end
                        if (last) begin
                            oMstReq <= 1'b0;
                            oDone   <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            oMstAddr <= oMstAddr + AW'(SW);
                            if (gap_q != '0) begin
                                oMstReq <= 1'b0;
                                state   <= ST_GAP;
                            end else if (oMstCmd == CMD_WR) begin
                                oMstReq  <= 1'b0;
                                oWrReady <= 1'b1;
                                state    <= ST_FETCH;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (t_zero) begin
                        if (oMstCmd == CMD_RD) begin
                            oMstReq <= 1'b1;
                            state   <= ST_REQ;
                        end else begin
                            oWrReady <= 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    oMstCmd    <= 1'b0;
                    oMstAddr   <= '0;
                    oMstSel    <= '0;
                    oMstWData  <= '0;
                    oBusy      <= 1'b0;
                    oDescReady <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_engine.sv
// tb_bus_master_engine: scoreboard bench with random descriptors and a queue-based bus model
module tb_bus_master_engine;

    localparam int AW = 12, DW = 32, SW = 4, LEN_W = 8, GAP_W = 4, TO_CYC = 8;

    logic             iClk = 1'b0;
    logic             iRst_n = 1'b0;
    logic             iDescValid = 1'b0;
    logic             oDescReady;
    logic             iDescCmd = 1'b0;
    logic [AW-1:0]    iDescAddr = '0;
    logic [SW-1:0]    iDescSel = '0;
    logic [LEN_W-1:0] iDescLen = '0;
    logic [GAP_W-1:0] iDescGap = '0;
    logic             iWrValid = 1'b0;
    logic             oWrReady;
    logic [DW-1:0]    iWrData = '0;
    logic             oRdValid;
    logic [DW-1:0]    oRdData;
    logic             oMstReq;
    logic             oMstCmd;
    logic [AW-1:0]    oMstAddr;
    logic [SW-1:0]    oMstSel;
    logic [DW-1:0]    oMstWData;
    logic             iMstAck = 1'b0;
    logic [DW-1:0]    iMstRData = '0;
    logic             oBusy;
    logic             oDone;
    logic             oErr;

    bus_master_engine #(
        .AW(AW), .DW(DW), .SW(SW), .LEN_W(LEN_W), .GAP_W(GAP_W), .TO_CYC(TO_CYC)
    ) dut (
        .iClk(iClk), .iRst_n(iRst_n),
        .iDescValid(iDescValid), .oDescReady(oDescReady), .iDescCmd(iDescCmd),
        .iDescAddr(iDescAddr), .iDescSel(iDescSel), .iDescLen(iDescLen), .iDescGap(iDescGap),
        .iWrValid(iWrValid), .oWrReady(oWrReady), .iWrData(iWrData),
        .oRdValid(oRdValid), .oRdData(oRdData),
        .oMstReq(oMstReq), .oMstCmd(oMstCmd), .oMstAddr(oMstAddr), .oMstSel(oMstSel),
        .oMstWData(oMstWData), .iMstAck(iMstAck), .iMstRData(iMstRData),
        .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic          cmd;
        logic [AW-1:0] addr;
        logic [SW-1:0] sel;
        logic [DW-1:0] wd;
    } beat_t;

    beat_t         exp_beats[$];
    logic [DW-1:0] exp_rd[$];
    logic          exp_done[$];
    logic [DW-1:0] wr_q[$];

    int   n_chk = 0, n_fail = 0, done_cnt = 0, idle_run = 0, ack_mode = 0;
    bit   pend_gap = 0;
    logic cur_cmd = 1'b0;
    int   cur_gap = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // bus slave: 0 = ack held high always, 1 = random ack (never more than 3 misses), 2 = never ack
    always @(posedge iClk) begin
        static int miss = 0;
        logic a;
        #1;
        iMstRData = $urandom;
        a = (ack_mode == 0) || (ack_mode == 1 && (($urandom_range(0, 2) != 0) || miss >= 3));
        iMstAck = a;
        miss = (oMstReq && !a) ? miss + 1 : 0;
    end

    // monitor: pops the scoreboard on acks, read strobes and done pulses
    always @(negedge iClk) begin
        beat_t b;
        if (!iRst_n) begin
            pend_gap = 0;
            idle_run = 0;
        end else begin
            if (!oBusy)
                check("idle_bus_zero", {oMstReq, oMstCmd, oMstAddr, oMstSel, oMstWData, oWrReady}, '0);
            if (oRdValid) begin
                if (exp_rd.size() == 0) check("rd_expected", 64'(exp_rd.size() != 0), 1);
                else check("rd_data", oRdData, exp_rd.pop_front());
            end
            if (oMstReq) begin
                if (pend_gap && cur_cmd) check("rd_gap_idle", idle_run, cur_gap);
                pend_gap = 0;
                idle_run = 0;
            end else idle_run++;
            if (oMstReq && iMstAck) begin
                if (exp_beats.size() == 0) check("beat_expected", 64'(exp_beats.size() != 0), 1);
                else begin
                    b = exp_beats.pop_front();
                    check("beat_cmd", oMstCmd, b.cmd);
                    check("beat_addr", oMstAddr, b.addr);
                    check("beat_sel", oMstSel, b.sel);
                    if (!b.cmd) check("beat_wdata", oMstWData, b.wd);
                    else exp_rd.push_back(iMstRData);
                end
                pend_gap = 1;
            end
            if (oDone) begin
                done_cnt++;
                pend_gap = 0;
                if (exp_done.size() == 0) check("done_expected", 64'(exp_done.size() != 0), 1);
                else check("done_err", oErr, exp_done.pop_front());
            end
        end
    end

    task automatic start_desc(input logic cmd, input logic [AW-1:0] addr, input logic [SW-1:0] sel,
                              input int len, input int gap, input logic err);
        beat_t b;
        int    w;
        w = 0;
        while (!oDescReady && w < 100) begin
            tick();
            w++;
        end
        check("desc_ready_wait", 64'(oDescReady), 1);
        for (int n = 0; n < len; n++) begin
            b.cmd  = cmd;
            b.addr = AW'((int'(addr) + n * SW) % (1 << AW));
            b.sel  = sel;
            b.wd   = cmd ? '0 : DW'($urandom);
            exp_beats.push_back(b);
            if (!cmd) wr_q.push_back(b.wd);
        end
        exp_done.push_back(err);
        cur_cmd    = cmd;
        cur_gap    = gap;
        iDescCmd   = cmd;
        iDescAddr  = addr;
        iDescSel   = sel;
        iDescLen   = LEN_W'(len);
        iDescGap   = GAP_W'(gap);
        iDescValid = 1'b1;
        tick();
        iDescValid = 1'b0;
    endtask

    task automatic feed_writes(input int mind, input int maxd);
        int w, d;
        while (wr_q.size() != 0) begin
            w = 0;
            while (!oWrReady && w < 200) begin
                tick();
                w++;
            end
            if (!oWrReady) begin
                check("wr_ready_wait", 64'(oWrReady), 1);
                wr_q.delete();
                return;
            end
            d = $urandom_range(mind, maxd);
            for (int i = 0; i < d; i++) begin
                check("wr_stall_req_low", oMstReq, 0);
                tick();
            end
            iWrValid = 1'b1;
            iWrData  = wr_q.pop_front();
            tick();
            iWrValid = 1'b0;
        end
    endtask

    task automatic wait_done(input int tgt);
        int w;
        w = 0;
        while (done_cnt < tgt && w < 3000) begin
            tick();
            w++;
        end
        check("done_reached", 64'(done_cnt >= tgt), 1);
    endtask

    task automatic run_desc(input logic cmd, input logic [AW-1:0] addr, input logic [SW-1:0] sel,
                            input int len, input int gap, input int mind, input int maxd);
        int tgt;
        tgt = done_cnt + 1;
        start_desc(cmd, addr, sel, len, gap, 1'b0);
        if (!cmd) feed_writes(mind, maxd);
        wait_done(tgt);
        check("beats_left", exp_beats.size(), 0);
        check("rd_left", exp_rd.size(), 0);
    endtask

    initial begin
        int w, c;
        // reset state
        tick();
        tick();
        check("rst_outputs", {oDescReady, oBusy, oMstReq, oDone, oErr, oRdValid, oWrReady}, '0);
        iRst_n = 1'b1;
        tick();
        check("ready_after_rst", oDescReady, 1);

        // write burst, immediate acks, data always valid
        ack_mode = 0;
        run_desc(1'b0, 12'h100, 4'hF, 4, 0, 0, 0);
        // read burst with wrap at the top of the address space and a 2-cycle gap
        run_desc(1'b1, 12'hFF8, 4'hF, 3, 2, 0, 0);
        // write data withheld: request must stay low until data arrives
        run_desc(1'b0, 12'h040, 4'h3, 2, 0, 5, 5);
        // zero-length descriptor
        c = done_cnt + 1;
        start_desc(1'b1, 12'h080, 4'hF, 0, 0, 1'b0);
        check("len0_done", oDone, 1);
        check("len0_req", oMstReq, 0);
        tick();
        check("len0_ready_after", oDescReady, 1);
        wait_done(c);

        // random descriptors against the scoreboard
        ack_mode = 1;
        for (int i = 0; i < 25; i++)
            run_desc(1'($urandom), AW'($urandom), SW'($urandom), $urandom_range(0, 6),
                     $urandom_range(0, 3), 0, 3);

        // reset while a request is pending
        ack_mode = 2;
        start_desc(1'b1, 12'h200, 4'hF, 4, 1, 1'b0);
        w = 0;
        while (!oMstReq && w < 50) begin
            tick();
            w++;
        end
        check("rst_test_req_up", oMstReq, 1);
        iRst_n = 1'b0;
        tick();
        check("rst_mid_req", oMstReq, 0);
        check("rst_mid_busy", oBusy, 0);
        iRst_n = 1'b1;
        exp_beats.delete();
        exp_rd.delete();
        exp_done.delete();
        wr_q.delete();
        ack_mode = 1;
        run_desc(1'b0, 12'h300, 4'hC, 3, 1, 0, 2);
        run_desc(1'b1, 12'h304, 4'hF, 3, 0, 0, 0);

`ifdef MST_TIMEOUT_EN
        // timeout: no ack ever, request holds TO_CYC cycles then aborts with error
        ack_mode = 2;
        c = done_cnt + 1;
        start_desc(1'b1, 12'h040, 4'hF, 3, 0, 1'b1);
        w = 0;
        while (!oMstReq && w < 50) begin
            tick();
            w++;
        end
        w = 0;
        while (oMstReq && w < 100) begin
            tick();
            w++;
        end
        check("to_req_cycles", w, TO_CYC);
        wait_done(c);
        check("to_err_sticky", oErr, 1);
        exp_beats.delete();
        ack_mode = 1;
        c = done_cnt + 1;
        start_desc(1'b1, 12'h050, 4'hF, 2, 0, 1'b0);
        check("to_err_cleared", oErr, 0);
        wait_done(c);
`endif

        tick();
        check("done_q_empty", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
